// File: rtl/dmem_responder_if.sv
// Load/store port between the core's memory stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering one byte/half/word load or store at a time; response pulse
// WAIT_CYCLES+1 cycles after accept, ready low until then, and no backpressure on the response.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        ready_c;

  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [0:DEPTH-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready_o = ready_c && !rst;
  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

  // With zero wait states the access commits on the accept edge, before the fields are latched.
  logic        cur_we, cur_uns;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  logic        commit;

  assign cur_we    = (state == IDLE) ? bus.req_we_i       : we_q;
  assign cur_uns   = (state == IDLE) ? bus.req_unsigned_i : uns_q;
  assign cur_size  = (state == IDLE) ? bus.req_size_i     : size_q;
  assign cur_addr  = (state == IDLE) ? bus.req_addr_i     : addr_q;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata_i    : wdata_q;
  assign commit    = (state_nxt == RESP) && (state != RESP);

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  err_c;
  logic [3:0]            be;
  logic [31:0]           wr_lanes;
  logic [31:0]           rd_shift;
  logic [31:0]           ld_data;

  assign word_idx = cur_addr[DEPTH_LOG2+1:2];
  assign rd_shift = mem[word_idx] >> {cur_addr[1:0], 3'b000};

  always_comb begin
    err_c    = |(cur_addr >> (DEPTH_LOG2 + 2));
    be       = 4'b0000;
    wr_lanes = cur_wdata;
    ld_data  = rd_shift;
    case (cur_size)
      2'b00: begin
        be       = 4'b0001 << cur_addr[1:0];
        wr_lanes = {4{cur_wdata[7:0]}};
        ld_data  = cur_uns ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      2'b01: begin
        if (cur_addr[0]) err_c = 1'b1;
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cur_wdata[15:0]}};
        ld_data  = cur_uns ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      2'b10: begin
        if (cur_addr[1:0] != 2'b00) err_c = 1'b1;
        be = 4'b1111;
      end
      default: err_c = 1'b1;
    endcase
  end

  // RAM is deliberately left out of reset; a store whose commit edge sees rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && cur_we && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        err_q   <= err_c;
        rdata_q <= (err_c || cur_we) ? 32'd0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid_i) begin
      we_q    <= bus.req_we_i;
      uns_q   <= bus.req_unsigned_i;
      size_q  <= bus.req_size_i;
      addr_q  <= bus.req_addr_i;
      wdata_q <= bus.req_wdata_i;
    end
  end
endmodule
